// File: rtl/div.sv
// Sequential 8-bit unsigned restoring divider: one quotient bit per CALC cycle,
// results and divisor exposed registered and as active-low seven-segment glyphs.
module div (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       ClearLoad,
    input  logic       Run,
    input  logic [7:0] S,
    output logic [7:0] Qval,
    output logic [7:0] Rval,
    output logic [7:0] Bval,
    output logic       Busy,
    output logic       DivZero,
    output logic [6:0] QhexU,
    output logic [6:0] QhexL,
    output logic [6:0] RhexU,
    output logic [6:0] RhexL
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t     r_state, w_next;
    logic [8:0] r_a;
    logic [7:0] r_q;
    logic [2:0] r_cnt;
    logic [7:0] r_qval, r_rval, r_bval;
    logic       r_busy, r_dz;

    logic [8:0] w_shift;
    logic [9:0] w_diff;
    logic       w_borrow;
    logic [8:0] w_a_nxt;
    logic [7:0] w_q_nxt;
    logic       w_bzero;

    assign w_bzero = (r_bval == 8'd0);

    // Trial subtraction; A[8] is always 0 so it only serves as the sign extension.
    always_comb begin
        w_shift  = {r_a[7:0], r_q[7]};
        w_diff   = {r_a[8], w_shift} - {2'b00, r_bval};
        w_borrow = w_diff[9];
        w_a_nxt  = w_borrow ? w_shift : w_diff[8:0];
        w_q_nxt  = {r_q[6:0], ~w_borrow};
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (Run) w_next = w_bzero ? DONE : CALC;
            CALC:    if (r_cnt == 3'd7) w_next = DONE;
            DONE:    if (!Run) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_a    <= '0;
            r_q    <= '0;
            r_cnt  <= '0;
            r_qval <= '0;
            r_rval <= '0;
            r_bval <= '0;
            r_busy <= 1'b0;
            r_dz   <= 1'b0;
        end else begin
            r_busy <= (w_next == CALC);
            case (r_state)
                IDLE: begin
                    // Run wins over ClearLoad when both are high.
                    if (Run) begin
                        if (!w_bzero) begin
                            r_q   <= S;
                            r_a   <= '0;
                            r_cnt <= '0;
                            r_dz  <= 1'b0;
                        end else begin
                            r_qval <= 8'hFF;
                            r_rval <= S;
                            r_dz   <= 1'b1;
                        end
                    end else if (ClearLoad) begin
                        r_bval <= S;
                        r_qval <= '0;
                        r_rval <= '0;
                        r_dz   <= 1'b0;
                    end
                end
                CALC: begin
                    r_a   <= w_a_nxt;
                    r_q   <= w_q_nxt;
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        r_qval <= w_q_nxt;
                        r_rval <= w_a_nxt[7:0];
                    end
                end
                default: ;
            endcase
        end
    end

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    assign Qval    = r_qval;
    assign Rval    = r_rval;
    assign Bval    = r_bval;
    assign Busy    = r_busy;
    assign DivZero = r_dz;
    assign QhexU   = hex7(r_qval[7:4]);
    assign QhexL   = hex7(r_qval[3:0]);
    assign RhexU   = hex7(r_rval[7:4]);
    assign RhexL   = hex7(r_rval[3:0]);

endmodule

// File: tb/tb_div.sv
// Randomized scoreboard bench for div: expected quotient/remainder pushed at issue,
// popped by a monitor whenever a division result appears.
module tb_div;
    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       ClearLoad = 1'b0;
    logic       Run = 1'b0;
    logic [7:0] S = 8'h00;
    logic [7:0] Qval, Rval, Bval;
    logic       Busy, DivZero;
    logic [6:0] QhexU, QhexL, RhexU, RhexL;

    div dut (
        .Clk(Clk), .Reset(Reset), .ClearLoad(ClearLoad), .Run(Run), .S(S),
        .Qval(Qval), .Rval(Rval), .Bval(Bval), .Busy(Busy), .DivZero(DivZero),
        .QhexU(QhexU), .QhexL(QhexL), .RhexU(RhexU), .RhexL(RhexL)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    logic [6:0] seg [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain unsigned division; zero divisor yields FF / dividend.
    function automatic exp_t model(input logic [7:0] b, input logic [7:0] d);
        exp_t e;
        if (b == 0) begin
            e.q = 8'hFF; e.r = d; e.dz = 1'b1;
        end else begin
            e.q = d / b; e.r = d % b; e.dz = 1'b0;
        end
        return e;
    endfunction

    // Monitor: a result is presented when Busy falls or DivZero rises.
    logic prev_busy = 1'b0, prev_dz = 1'b0;
    always @(negedge Clk) begin
        if (Reset && ((prev_busy && !Busy) || (!prev_dz && DivZero))) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("Qval", Qval, e.q);
                check("Rval", Rval, e.r);
                check("DivZero", DivZero, e.dz);
                check("QhexU", QhexU, seg[e.q[7:4]]);
                check("QhexL", QhexL, seg[e.q[3:0]]);
                check("RhexU", RhexU, seg[e.r[7:4]]);
                check("RhexL", RhexL, seg[e.r[3:0]]);
            end
        end
        prev_busy = Busy;
        prev_dz   = DivZero;
    end

    task automatic load(input logic [7:0] b);
        @(posedge Clk); #1;
        S = b; ClearLoad = 1'b1;
        @(posedge Clk); #1;
        ClearLoad = 1'b0;
        check("Bval_load", Bval, b);
        check("Busy_after_load", Busy, 1'b0);
    endtask

    // Run one division, holding Run for 'hold' sampled cycles (>=1).
    task automatic do_div(input logic [7:0] b, input logic [7:0] d, input int hold,
                          input bit mid_cl);
        int nb;
        logic [7:0] pre_q;
        load(b);
        sb.push_back(model(b, d));
        pre_q = Qval;
        nb = 0;
        S = d; Run = 1'b1;
        for (int c = 0; c < 12 + hold; c++) begin
            @(negedge Clk);
            if (Busy) begin
                nb++;
                if (Qval !== pre_q) check("Qval_hold", Qval, pre_q);
                S = $urandom_range(0, 255);
                if (mid_cl && nb == 3) ClearLoad = 1'b1;
                if (mid_cl && nb == 3) S = 8'h03;
                if (mid_cl && nb == 4) ClearLoad = 1'b0;
            end
            if (c == hold) Run = 1'b0;
        end
        ClearLoad = 1'b0;
        check("busy_cycles", nb, (b == 0) ? 0 : 8);
        check("Bval_kept", Bval, b);
    endtask

    initial begin
        #22;
        check("rst_Qval", Qval, 8'h00);
        check("rst_Rval", Rval, 8'h00);
        check("rst_Bval", Bval, 8'h00);
        check("rst_Busy", Busy, 1'b0);
        check("rst_DivZero", DivZero, 1'b0);
        check("rst_hex", {QhexU, QhexL, RhexU, RhexL}, {4{7'h40}});
        @(negedge Clk); Reset = 1'b1;

        do_div(8'h07, 8'hC8, 1, 1'b0);
        do_div(8'h01, 8'hFF, 1, 1'b0);
        do_div(8'h09, 8'h05, 1, 1'b0);
        do_div(8'h00, 8'h2A, 1, 1'b0);
        do_div(8'h0D, 8'hF1, 20, 1'b0);
        do_div(8'h05, 8'h64, 1, 1'b1);

        // Asynchronous reset at iteration 4
        load(8'h07);
        S = 8'hC8; Run = 1'b1;
        for (int c = 0; c < 5; c++) @(negedge Clk);
        #2 Reset = 1'b0;
        #1;
        check("midrst_Qval", Qval, 8'h00);
        check("midrst_Rval", Rval, 8'h00);
        check("midrst_Bval", Bval, 8'h00);
        check("midrst_Busy", Busy, 1'b0);
        check("midrst_hex", {QhexU, QhexL, RhexU, RhexL}, {4{7'h40}});
        Run = 1'b0;
        @(negedge Clk); @(negedge Clk);
        Reset = 1'b1;
        do_div(8'h07, 8'hC8, 1, 1'b0);

        for (int i = 0; i < 30; i++) begin
            logic [7:0] b, d;
            b = $urandom_range(0, 255);
            if ($urandom_range(0, 7) == 0) b = 8'h00;
            if ($urandom_range(0, 3) == 0) b = $urandom_range(1, 15);
            d = $urandom_range(0, 255);
            do_div(b, d, $urandom_range(1, 3), 1'b0);
        end

        repeat (4) @(negedge Clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/div.md
# div

Sequential 8-bit unsigned restoring divider; the inverse operation to the team's shift-add multiplier, driven by the same board inputs. The divisor is loaded from the slider switches with one push-button. The dividend is taken from the switches when Run is pressed. Quotient and remainder are computed over 8 iterations and shown on four hex displays and on parallel outputs.

## Interface
- No parameters; the data width is fixed at 8.
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low; clears all state and outputs.
- ClearLoad  in  1  active-high, already synchronized upstream; in IDLE, loads the divisor from S and clears the results.
- Run  in  1  active-high, already synchronized upstream; starts one division and is edge-qualified via the DONE hold.
- S  in  8  slider switches; carries the divisor on ClearLoad and the dividend on Run.
- Qval  out  8  quotient, registered.
- Rval  out  8  remainder, registered.
- Bval  out  8  stored divisor, registered.
- Busy  out  1  registered; high while in CALC.
- DivZero  out  1  registered; set by a division whose divisor was 0.
- QhexU, QhexL, RhexU, RhexL  out  7 each  active-low seven-segment decode of the Qval/Rval nibbles.
  - Bit 0 is segment a, bit 6 is segment g.
  - Glyph codes: 0→7'h40, 1→7'h79, 4→7'h19, C→7'h46, F→7'h0E.

## Operation
- The block keeps a working remainder register A (9 bits), a working quotient register Q (8 bits) and a 3-bit iteration counter. These are separate from the Qval/Rval output registers.
- States and transitions:
  - IDLE → CALC: when Run=1 and Bval≠0.
  - IDLE → DONE: when Run=1 and Bval=0 (divide-by-zero path).
  - CALC → DONE: after the 8th iteration.
  - DONE → IDLE: when Run=0.
  - While Run stays high in DONE, the block stays in DONE, so exactly one division runs per press.
- IDLE actions:
  - On ClearLoad=1 and Run=0: Bval←S, Qval←0, Rval←0, DivZero←0.
  - If Run and ClearLoad are high in the same cycle, Run takes priority and ClearLoad is ignored.
- Start of a division (the IDLE→CALC edge): Q←S, A←0, counter←0, DivZero←0.
- Each CALC cycle performs one iteration:
  - Form T = {A[7:0], Q[7]} − {1'b0, Bval}, as a 9-bit result with an explicit borrow.
  - If there is no borrow: A←T and Q←{Q[6:0],1}.
  - Otherwise: A←{A[7:0],Q[7]} and Q←{Q[6:0],0}.
  - Then the counter increments.
- On the CALC→DONE edge: Qval←final Q, Rval←final A[7:0].
- On the divide-by-zero path (IDLE→DONE edge): Qval←8'hFF, Rval←S, DivZero←1.
- Arithmetic rules:
  - Both operands are unsigned.
  - The remainder always satisfies Rval < Bval and Qval·Bval + Rval = dividend.
  - A never exceeds 8 significant bits after an iteration.
- ClearLoad is ignored in CALC and DONE.
- S changes during CALC do not affect the result, because the dividend was latched at start.
- Qval and Rval hold their previous values throughout CALC. Only the final result is ever visible on them.

## Timing
- Reset values:
  - Qval=0, Rval=0, Bval=0, Busy=0, DivZero=0.
  - All hex outputs = 7'h40 (glyph "0").
  - State = IDLE.
- Latency, with edge 0 being the edge that samples Run=1 in IDLE:
  - Busy=1 after edges 0 through 7.
  - At edge 8, the state enters DONE, Busy=0, and Qval/Rval are valid.
  - Total: 9 edges from the sampling of Run to the result.
- Divide-by-zero: the result and DivZero are valid after edge 0, and Busy never asserts.
- ClearLoad: Bval is updated at the first edge at which ClearLoad=1 is sampled in IDLE.
- The hex outputs are a combinational decode of the registered Qval/Rval, so they add no lag.
- Reset assertion mid-CALC:
  - Clears all state immediately, without waiting for a clock edge.
  - No partial result ever appears on Qval or Rval.
- Back-to-back divisions require Run=0 for at least one edge between presses.

## Test plan
- Reset → all outputs at their reset values, hex outputs = 7'h40. Then ClearLoad with S=8'h07 → Bval=8'h07, Busy still 0.
- Divisor 8'h07, Run with S=8'hC8 (200) → Busy high for 8 cycles, then Qval=8'h1C, Rval=8'h04, QhexU=7'h79, QhexL=7'h46, RhexL=7'h19.
- Divisor 8'h01, dividend 8'hFF → Qval=8'hFF, Rval=0.
- Divisor 8'h09, dividend 8'h05 → Qval=0, Rval=8'h05.
- Run held high across the full division: no second division runs, and DONE persists until Run=0.
- Divisor 0, dividend 8'h2A → after 1 edge Qval=8'hFF, Rval=8'h2A, DivZero=1, Busy never high.
- Reset asserted at iteration 4 → outputs return to reset values immediately, and the next Run computes a correct result.
- ClearLoad pulsed with S=8'h03 mid-CALC → Bval is unchanged and the result uses the old divisor.
